// File: rtl/jtag_reg_access_pkg.sv
// Shared constants for the debug-side GPR access sequencer.
// The GPR geometry matches the register file this block sits in front of.
package jtag_reg_access_pkg;

    // Register-file geometry: 32 general-purpose registers of 32 bits each.
    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 32;

    // Width needed to count write attempts up to and including max_attempts.
    function automatic int retry_cnt_width(input int max_attempts);
        int w;
        w = $clog2(max_attempts + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/jtag_reg_access.sv
// Debug-side GPR access sequencer. It accepts single read or write requests
// from the JTAG debug module and drives the register file's JTAG port. The
// register file lets EX write-back win over a JTAG write, so any cycle with
// an EX write to a real register (not x0) is treated as a lost JTAG write.
// The write is then retried, up to RETRY_MAX attempts, before an error
// response is returned.
module jtag_reg_access
    import jtag_reg_access_pkg::*;
#(
    parameter int ADDR_W       = GPR_ADDR_W,
    parameter int DATA_W       = GPR_DATA_W,
    parameter int RETRY_MAX    = 8,
    parameter bit REQUIRE_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,

    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_err_o,

    input  logic              core_halted_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,

    output logic              jtag_we_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [DATA_W-1:0] jtag_data_o,
    input  logic [DATA_W-1:0] jtag_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int               CNT_W      = retry_cnt_width(RETRY_MAX);
    localparam logic [CNT_W-1:0] LAST_RETRY = CNT_W'(RETRY_MAX - 1);

    state_t           state;
    logic             we_q;
    logic [CNT_W-1:0] retry_cnt;
    logic             collision;

    // An EX write-back to x0 never reaches the array, so it does not block
    // the JTAG write; every other EX write in the same cycle does.
    assign collision = ex_we_i && (ex_waddr_i != '0);

    // The write enable comes straight from the state register, so a reset
    // removes it immediately without waiting for a clock edge.
    assign jtag_we_o = (state == ACCESS) && we_q;

    // Request/response sequencing, retry counting and registered outputs.
    // Address and data stay latched outside ACCESS so the register file's
    // read port sees a stable index while the response is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
            jtag_addr_o  <= '0;
            jtag_data_o  <= '0;
            we_q         <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        jtag_addr_o <= req_addr_i;
                        jtag_data_o <= req_wdata_i;
                        we_q        <= req_we_i;
                        req_ready_o <= 1'b0;
                        if (REQUIRE_HALT && !core_halted_i) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_data_o  <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (!we_q) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= jtag_rdata_i;
                    end else if (!collision) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_data_o  <= '0;
                    end else if (retry_cnt == LAST_RETRY) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_data_o  <= '0;
                        retry_cnt    <= retry_cnt + CNT_W'(1);
                    end else begin
                        retry_cnt <= retry_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        retry_cnt    <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_reg_access.sv
// Self-checking bench for jtag_reg_access. A behavioural register file
// (EX write priority, x0 hard-wired to zero) sits on the JTAG port, and a
// transaction-level reference model predicts latency, response data/error
// and the final register contents.
module tb_jtag_reg_access;

    localparam int RETRY_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        core_halted_i;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata;
    logic        jtag_we_o;
    logic [4:0]  jtag_addr_o;
    logic [31:0] jtag_data_o;
    logic [31:0] jtag_rdata_i;

    logic [31:0] gpr [32];
    logic [31:0] ref_gpr [32];

    int tests_run = 0;
    int tests_failed = 0;

    jtag_reg_access #(
        .ADDR_W       (5),
        .DATA_W       (32),
        .RETRY_MAX    (RETRY_MAX),
        .REQUIRE_HALT (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .core_halted_i (core_halted_i),
        .ex_we_i       (ex_we_i),
        .ex_waddr_i    (ex_waddr_i),
        .jtag_we_o     (jtag_we_o),
        .jtag_addr_o   (jtag_addr_o),
        .jtag_data_o   (jtag_data_o),
        .jtag_rdata_i  (jtag_rdata_i)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Register file stand-in: EX write-back wins over the JTAG write port.
    always_ff @(posedge clk) begin
        if (ex_we_i && ex_waddr_i != 5'd0)
            gpr[ex_waddr_i] <= ex_wdata;
        else if (jtag_we_o && jtag_addr_o != 5'd0)
            gpr[jtag_addr_o] <= jtag_data_o;
    end

    assign jtag_rdata_i = (jtag_addr_o == 5'd0) ? 32'd0 : gpr[jtag_addr_o];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One full request/response transaction. n_coll is the number of
    // leading ACCESS cycles with a colliding EX write; zero_ex drives EX
    // writes to x0 on the other cycles; reset_after >= 0 asserts reset in
    // that ACCESS cycle and abandons the transaction.
    task automatic applyStimulus(input bit halted, input bit we,
                                 input logic [4:0] addr, input logic [31:0] wdata,
                                 input int n_coll, input bit zero_ex,
                                 input int ready_delay, input int reset_after);
        int          access_cycles;
        bit          exp_err;
        logic [31:0] exp_data;

        checkOutput("idle_req_ready", 64'(req_ready_o), 64'd1);
        req_valid_i   = 1'b1;
        req_we_i      = we;
        req_addr_i    = addr;
        req_wdata_i   = wdata;
        core_halted_i = halted;
        @(posedge clk); #1;
        req_valid_i   = 1'b0;
        req_we_i      = 1'($urandom);
        req_addr_i    = 5'($urandom);
        req_wdata_i   = $urandom;
        core_halted_i = 1'($urandom);
        checkOutput("busy_req_ready", 64'(req_ready_o), 64'd0);

        if (!halted) begin
            access_cycles = 0; exp_err = 1'b1; exp_data = 32'd0;
        end else if (!we) begin
            access_cycles = 1; exp_err = 1'b0;
            exp_data = (addr == 5'd0) ? 32'd0 : ref_gpr[addr];
        end else if (n_coll >= RETRY_MAX) begin
            access_cycles = RETRY_MAX; exp_err = 1'b1; exp_data = 32'd0;
        end else begin
            access_cycles = n_coll + 1; exp_err = 1'b0; exp_data = 32'd0;
        end

        for (int k = 0; k < access_cycles; k++) begin
            if (reset_after == k) begin
                ex_we_i = 1'b0;
                rst = 1'b1;
                #1;
                checkOutput("rst_jtag_we", 64'(jtag_we_o), 64'd0);
                checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'd0);
                checkOutput("rst_req_ready", 64'(req_ready_o), 64'd1);
                checkOutput("rst_resp_err", 64'(resp_err_o), 64'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            checkOutput("acc_jtag_we", 64'(jtag_we_o), 64'(we));
            checkOutput("acc_jtag_addr", 64'(jtag_addr_o), 64'(addr));
            if (we)
                checkOutput("acc_jtag_data", 64'(jtag_data_o), 64'(wdata));
            checkOutput("acc_resp_valid", 64'(resp_valid_o), 64'd0);
            if (we && k < n_coll) begin
                ex_we_i    = 1'b1;
                ex_waddr_i = 5'($urandom_range(31, 1));
                ex_wdata   = $urandom;
                ref_gpr[ex_waddr_i] = ex_wdata;
            end else if (zero_ex) begin
                ex_we_i    = 1'b1;
                ex_waddr_i = 5'd0;
                ex_wdata   = $urandom;
            end else begin
                ex_we_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        ex_we_i = 1'b0;
        if (halted && we && !exp_err && addr != 5'd0)
            ref_gpr[addr] = wdata;

        for (int d = 0; d <= ready_delay; d++) begin
            checkOutput("resp_valid", 64'(resp_valid_o), 64'd1);
            checkOutput("resp_err", 64'(resp_err_o), 64'(exp_err));
            checkOutput("resp_data", 64'(resp_data_o), 64'(exp_data));
            checkOutput("resp_req_ready", 64'(req_ready_o), 64'd0);
            checkOutput("resp_jtag_we", 64'(jtag_we_o), 64'd0);
            checkOutput("resp_addr_hold", 64'(jtag_addr_o), 64'(addr));
            resp_ready_i = (d == ready_delay);
            @(posedge clk); #1;
        end
        resp_ready_i = 1'b0;
        checkOutput("post_resp_valid", 64'(resp_valid_o), 64'd0);
        checkOutput("post_req_ready", 64'(req_ready_o), 64'd1);
    endtask

    // Main sequence: preload during reset, directed cases, random traffic,
    // then a readback sweep of the whole register file.
    initial begin
        logic [31:0] preload;
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_we_i      = 1'b0;
        req_addr_i    = 5'd0;
        req_wdata_i   = 32'd0;
        resp_ready_i  = 1'b0;
        core_halted_i = 1'b1;
        ex_we_i       = 1'b0;
        ex_waddr_i    = 5'd0;
        ex_wdata      = 32'd0;
        ref_gpr[0]    = 32'd0;

        for (int i = 1; i < 32; i++) begin
            preload       = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            ex_we_i       = 1'b1;
            ex_waddr_i    = 5'(i);
            ex_wdata      = preload;
            ref_gpr[i]    = preload;
            @(posedge clk); #1;
        end
        ex_we_i = 1'b0;

        checkOutput("reset_req_ready", 64'(req_ready_o), 64'd1);
        checkOutput("reset_resp_valid", 64'(resp_valid_o), 64'd0);
        checkOutput("reset_resp_data", 64'(resp_data_o), 64'd0);
        checkOutput("reset_resp_err", 64'(resp_err_o), 64'd0);
        checkOutput("reset_jtag_we", 64'(jtag_we_o), 64'd0);
        checkOutput("reset_jtag_addr", 64'(jtag_addr_o), 64'd0);
        checkOutput("reset_jtag_data", 64'(jtag_data_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b0, 5'd5, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h1234_5678, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b0, 5'd7, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hA5A5_A5A5, 2, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0BAD_F00D, RETRY_MAX, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'hCAFE_0004, 0, 1'b1, 1, -1);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'hCAFE_1004, RETRY_MAX - 1, 1'b1, 0, -1);
        applyStimulus(1'b1, 1'b0, 5'd4, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b0, 1'b1, 5'd1, 32'hFFFF_FFFF, 0, 1'b0, 5, -1);
        applyStimulus(1'b1, 1'b0, 5'd1, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h5555_AAAA, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h7777_7777, RETRY_MAX, 1'b0, 0, 3);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'd0, 0, 1'b0, 0, -1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h8888_8888, 1, 1'b0, 2, -1);
        applyStimulus(1'b1, 1'b0, 5'd3, 32'd0, 0, 1'b0, 0, -1);

        for (int t = 0; t < 80; t++) begin
            applyStimulus(($urandom_range(9, 0) != 0), 1'($urandom),
                          5'($urandom), $urandom,
                          ($urandom_range(3, 0) == 0) ? int'($urandom_range(RETRY_MAX + 2, 0))
                                                      : int'($urandom_range(2, 0)),
                          1'($urandom), int'($urandom_range(3, 0)), -1);
        end

        for (int a = 0; a < 32; a++)
            applyStimulus(1'b1, 1'b0, 5'(a), 32'd0, 0, 1'b0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jtag_reg_access.md
Name: jtag_reg_access

Overview:
Debug-side access sequencer that sits directly upstream of the general-purpose register file's JTAG port. It drives the register file's JTAG write-enable, address and write-data inputs, and consumes its JTAG read-data output. It turns valid/ready requests from the JTAG debug module into single GPR reads or writes. The register file gives EX writes priority over JTAG writes, so this block detects that collision and retries the write, returning a response with a data/error indication.

Parameters:
ADDR_W, 5, GPR address width (32 registers)
DATA_W, 32, GPR data width
RETRY_MAX, 8, maximum collided write attempts before an error response (range 1..255)
REQUIRE_HALT, 1, 1 = reject accesses unless the core reports halted

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid_i  in  1  debug request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDR_W  GPR index
req_wdata_i  in  DATA_W  write data
resp_valid_o  out  1  response valid
resp_ready_i  in  1  debug module takes response
resp_data_o  out  DATA_W  read data (0 for writes/errors)
resp_err_o  out  1  1 = access failed
core_halted_i  in  1  core halted status
ex_we_i  in  1  EX write-back enable (same signal feeding the register file)
ex_waddr_i  in  ADDR_W  EX write-back address
jtag_we_o  out  1  to register file JTAG write enable
jtag_addr_o  out  ADDR_W  to register file JTAG address
jtag_data_o  out  DATA_W  to register file JTAG write data
jtag_rdata_i  in  DATA_W  from register file JTAG read data (combinational)

Behaviour:
- Reset (async, immediate):
  - state IDLE; req_ready_o=1; resp_valid_o=0; resp_data_o=0; resp_err_o=0.
  - jtag_we_o=0; jtag_addr_o=0; jtag_data_o=0; retry counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_o=1, and it is asserted only in IDLE.
  - On req_valid_i, latch we/addr/wdata into jtag_addr_o/jtag_data_o and a we flag.
  - If REQUIRE_HALT=1 and core_halted_i=0 at acceptance: go to RESP with err=1, data=0; no register-file access.
  - Otherwise go to ACCESS.
- ACCESS, read:
  - jtag_we_o=0.
  - Capture jtag_rdata_i into resp_data_o, err=0, go to RESP.
  - Address 0 returns 0 because the register file supplies 0.
- ACCESS, write:
  - jtag_we_o=1 combinationally from state and latched we.
  - Collision = ex_we_i && ex_waddr_i!=0 in this cycle.
  - No collision: write is taken; go to RESP, err=0, data=0.
  - Collision: increment counter and stay in ACCESS.
  - Counter reaching RETRY_MAX: go to RESP with err=1. The register file is unchanged by this block.
  - Write to x0 completes with err=0 and has no effect.
- RESP:
  - resp_valid_o=1, with data/err held stable until resp_ready_i.
  - On handshake: go to IDLE, clear counter, drop resp_valid_o the next cycle.
  - A new request is accepted no earlier than the cycle after the response handshake.
- jtag_addr_o/jtag_data_o hold their latched values outside ACCESS, so the register file's JTAG read port is stable. jtag_we_o is high only in ACCESS for writes.
- Latency, no collision: accept at cycle N, access at N+1, resp_valid_o at N+2. Each collision adds 1 cycle.
- core_halted_i is sampled only at acceptance. Deasserting it mid-operation does not abort.
- Reset mid-operation: transaction dropped, no response, and jtag_we_o deasserts asynchronously.

Decomposition:
- Shared package/defines: ADDR_W/DATA_W come from the existing register-address and register-data width constants. FSM state encodings live as local constants in the module, not in the package.
- No sub-module: a single FSM plus a counter.

Test Plan:
- Halted, read x5 (preloaded 0xDEADBEEF), resp_ready_i=1 -> resp_valid_o at N+2, resp_data_o=0xDEADBEEF, resp_err_o=0.
- Halted, write x7=0x12345678, ex_we_i=0 -> jtag_we_o high exactly one cycle with jtag_addr_o=7; a subsequent read of x7 returns 0x12345678.
- Write x3=0xA5A5A5A5 while ex_we_i=1, ex_waddr_i=9 for 2 cycles -> jtag_we_o held for 3 cycles, resp at N+4, err=0, x3=0xA5A5A5A5.
- RETRY_MAX=8, ex write active continuously -> err=1 after 8 ACCESS cycles, x3 unchanged; ex_waddr_i=0 does not count as a collision.
- core_halted_i=0, write x1 -> resp at N+1 with err=1, jtag_we_o never asserted. Then resp_ready_i=0 for 5 cycles -> resp_valid_o, data and err stable, req_ready_o=0.
- Assert rst during ACCESS of a collided write -> jtag_we_o, resp_valid_o and req_ready_o take reset values immediately; the next request behaves normally.
